// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helpers for the synchronous register-file FIFO.
//   DEF_B         : default data width in bits
//   DEF_W         : default address width (depth = 2**W)
//   DEF_AF_MARGIN : default almost-full margin (free entries)
//   cnt_width()   : width of an entry counter able to hold 0..2**W
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEF_B         = 8;
  localparam int DEF_W         = 4;
  localparam int DEF_AF_MARGIN = 1;

  // A counter must represent both 0 and 2**W, so it needs one extra bit.
  function automatic int cnt_width(input int w);
    return w + 1;
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// 2**W x B register-array storage. One synchronous write port and one
// combinational read port. Contents are never reset.
// Ports:
//   clk     in  1  rising-edge clock
//   we      in  1  write enable
//   w_addr  in  W  write address
//   w_data  in  B  write data
//   r_addr  in  W  read address
//   r_data  out B  read data (combinational from r_addr)
// -----------------------------------------------------------------------------
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int B = DEF_B,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  localparam int DEPTH = 1 << W;

  logic [B-1:0] mem_r [DEPTH];

  // Storage write: one entry per accepted push, no reset on the array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[w_addr] <= w_data;
    end
  end

  // Show-ahead read path.
  assign r_data = mem_r[r_addr];

endmodule : fifo_mem

// File: rtl/sync_fifo_rf.sv
// -----------------------------------------------------------------------------
// sync_fifo_rf
// Synchronous FIFO built on a register array (fifo_mem) with a show-ahead
// read port, registered status flags and sticky overflow/underflow errors.
// Optional feature: define FIFO_LEVEL_EN to expose the entry count on 'level'.
// Parameters:
//   B         data width
//   W         address width, depth = 2**W
//   AF_MARGIN almost_full asserts when free entries <= AF_MARGIN
// Ports:
//   clk          in  1    rising-edge clock
//   reset        in  1    synchronous active-high reset
//   wr           in  1    push request
//   rd           in  1    pop request
//   w_data       in  B    push data
//   r_data       out B    head-of-queue data (valid when empty=0)
//   empty        out 1    no entries held
//   full         out 1    2**W entries held
//   almost_full  out 1    free entries <= AF_MARGIN
//   ovf_err      out 1    sticky: push attempted while full
//   udf_err      out 1    sticky: pop attempted while empty
//   level        out W+1  entry count (FIFO_LEVEL_EN only)
// -----------------------------------------------------------------------------
module sync_fifo_rf
  import sync_fifo_pkg::*;
#(
  parameter int B         = DEF_B,
  parameter int W         = DEF_W,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_full,
  output logic         ovf_err,
  output logic         udf_err
`ifdef FIFO_LEVEL_EN
  ,
  output logic [W:0]   level
`endif
);

  localparam int CW    = cnt_width(W);
  localparam int DEPTH = 1 << W;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  // A margin at or beyond the depth means almost_full is permanently high.
  localparam logic          AF_ALWAYS = (AF_MARGIN >= DEPTH) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] AF_C      = AF_ALWAYS ? DEPTH_C : CW'(AF_MARGIN);

  logic [W-1:0]  wr_ptr_r;
  logic [W-1:0]  rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          empty_r;
  logic          full_r;
  logic          af_r;
  logic          ovf_r;
  logic          udf_r;

  logic          push_ok_s;
  logic          pop_ok_s;
  logic [CW-1:0] cnt_nxt_s;
  logic [CW-1:0] free_nxt_s;
  logic          af_nxt_s;

  // Accept logic: a pop needs data; a push needs room, or a pop freeing a
  // slot in the same cycle (full with rd=1).
  always_comb begin
    pop_ok_s  = rd & ~empty_r;
    push_ok_s = wr & (~full_r | pop_ok_s);
  end

  // Next entry count and the almost-full flag derived from it.
  always_comb begin
    cnt_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_nxt_s = count_r + CW'(1);
      2'b01:   cnt_nxt_s = count_r - CW'(1);
      default: cnt_nxt_s = count_r;
    endcase
    free_nxt_s = DEPTH_C - cnt_nxt_s;
    if (AF_ALWAYS) begin
      af_nxt_s = 1'b1;
    end else begin
      af_nxt_s = (free_nxt_s <= AF_C);
    end
  end

  // Pointer, count, flag and sticky-error registers; reset wins over wr/rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      af_r     <= AF_ALWAYS;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + W'(1);
      end
      count_r <= cnt_nxt_s;
      empty_r <= (cnt_nxt_s == '0);
      full_r  <= (cnt_nxt_s == DEPTH_C);
      af_r    <= af_nxt_s;
      // Push rejected only when full and no pop accompanies it.
      if (wr & full_r & ~rd) begin
        ovf_r <= 1'b1;
      end
      if (rd & empty_r) begin
        udf_r <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .B (B),
    .W (W)
  ) u_mem (
    .clk    (clk),
    .we     (push_ok_s),
    .w_addr (wr_ptr_r),
    .w_data (w_data),
    .r_addr (rd_ptr_r),
    .r_data (r_data)
  );

  assign empty       = empty_r;
  assign full        = full_r;
  assign almost_full = af_r;
  assign ovf_err     = ovf_r;
  assign udf_err     = udf_r;

`ifdef FIFO_LEVEL_EN
  assign level = count_r;
`endif

endmodule : sync_fifo_rf
